// File: rtl/c499_ctrl_pkg.sv
// Shared types and constants for the c499 key/sequence controller.
package c499_ctrl_pkg;

  // Default widths of the locked c499 core interface
  localparam int C499_KEY_W  = 26;
  localparam int C499_DATA_W = 32;
  localparam int C499_CHK_W  = 8;

  // Position of the mux keys (p1..p4) and XOR keys (X_1..X_22) in the key word
  localparam int P_LSB = 0;
  localparam int X_LSB = 4;

  // Width of the settle counter; SETTLE must fit in 1..15
  localparam int SCNT_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_UNKEYED = 2'd0,
    ST_READY   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_HOLD    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/c499_key_shift.sv
// Serial key shadow register with a saturating bit counter.
// The first bit shifted in ends up in the MSB once KEY_W bits have arrived.
module c499_key_shift #(
  parameter int KEY_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sdi,
  input  logic             shift_en,
  input  logic             clr_cnt,
  output logic [KEY_W-1:0] shadow,
  output logic             full
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(KEY_W);

  logic [CNT_W-1:0] bit_cnt;

  // Shift the shadow and count bits up to KEY_W; the count is cleared once the key is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) begin
        shadow <= {shadow[KEY_W-2:0], sdi};
      end
      if (clr_cnt) begin
        bit_cnt <= '0;
      end else if (shift_en && (bit_cnt != CNT_MAX)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign full = (bit_cnt == CNT_MAX);

endmodule

// File: rtl/c499_key_seq_ctrl.sv
// Key loading and codeword sequencing for the key-locked c499 SEC core.
// Optional build macro C499_KEY_SCRUB_EN: when defined, key_out shows the
// committed key only while a word is settling through the core, else 0.
module c499_key_seq_ctrl
  import c499_ctrl_pkg::*;
#(
  parameter int KEY_W  = C499_KEY_W,
  parameter int DATA_W = C499_DATA_W,
  parameter int CHK_W  = C499_CHK_W,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_sdi,
  input  logic              key_sen,
  input  logic              key_commit,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_ok,
  output logic              key_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic [DATA_W-1:0] core_data,
  output logic [CHK_W-1:0]  core_chk,
  output logic              core_en,
  input  logic [DATA_W-1:0] core_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [SCNT_W-1:0] SETTLE_INIT = SCNT_W'(SETTLE - 1);

  ctrl_state_t       state;
  logic [SCNT_W-1:0] settle_cnt;
  logic              commit_pending;
  logic [KEY_W-1:0]  key_reg;
  logic [KEY_W-1:0]  shadow;
  logic              key_full;
  logic              commit_ok;
  logic              commit_bad;
  logic              accept;
  logic              apply_key;
  logic              shift_en;

  // A commit is only honoured with a full shadow; a commit always blocks the shift in its cycle
  assign commit_ok  = key_commit & key_full;
  assign commit_bad = key_commit & ~key_full;
  assign shift_en   = key_sen & ~key_commit & ~commit_pending;
  assign accept     = (state == ST_READY) & in_valid & in_ready;

  // Key is applied immediately when idle, or deferred to the edge that returns to READY
  assign apply_key = (commit_ok & ((state == ST_UNKEYED) | (state == ST_READY))) |
                     ((state == ST_HOLD) & out_ready & (commit_pending | commit_ok));

  c499_key_shift #(
    .KEY_W (KEY_W)
  ) u_key_shift (
    .clk      (clk),
    .rst      (rst),
    .sdi      (key_sdi),
    .shift_en (shift_en),
    .clr_cnt  (apply_key),
    .shadow   (shadow),
    .full     (key_full)
  );

`ifdef C499_KEY_SCRUB_EN
  logic key_vis;

  // Expose the key only while a word sits in the core
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_vis <= 1'b0;
    end else if (accept) begin
      key_vis <= 1'b1;
    end else if ((state == ST_SETTLE) && (settle_cnt == '0)) begin
      key_vis <= 1'b0;
    end
  end

  assign key_out = key_vis ? key_reg : '0;
`else
  assign key_out = key_reg;
`endif

  // Sequencer: key commit bookkeeping, handshake and core timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_UNKEYED;
      settle_cnt     <= '0;
      commit_pending <= 1'b0;
      key_reg        <= '0;
      key_ok         <= 1'b0;
      key_err        <= 1'b0;
      in_ready       <= 1'b0;
      core_data      <= '0;
      core_chk       <= '0;
      core_en        <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
    end else begin
      if (commit_bad) begin
        key_err <= 1'b1;
      end
      if (apply_key) begin
        key_reg        <= shadow;
        key_ok         <= 1'b1;
        commit_pending <= 1'b0;
      end
      case (state)
        ST_UNKEYED: begin
          if (commit_ok) begin
            state    <= ST_READY;
            in_ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (accept) begin
            core_data  <= in_data;
            core_chk   <= in_chk;
            core_en    <= 1'b1;
            settle_cnt <= SETTLE_INIT;
            in_ready   <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (commit_ok) begin
            commit_pending <= 1'b1;
          end
          if (settle_cnt == '0) begin
            out_data  <= core_dout;
            out_valid <= 1'b1;
            core_en   <= 1'b0;
            state     <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - SCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_READY;
          end else if (commit_ok) begin
            commit_pending <= 1'b1;
          end
        end
        default: state <= ST_UNKEYED;
      endcase
    end
  end

endmodule

// File: tb/tb_c499_key_seq_ctrl.sv
// Directed self-checking bench for c499_key_seq_ctrl (SETTLE = 2).
// The core is stubbed as core_dout = core_data ^ 1.
module tb_c499_key_seq_ctrl;

  localparam int KEY_W  = 26;
  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int SETTLE = 2;

`ifdef C499_KEY_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  localparam logic [KEY_W-1:0] KEY_A = 26'h2AAAAAA;
  localparam logic [KEY_W-1:0] KEY_B = 26'h1555555;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_sdi;
  logic              key_sen;
  logic              key_commit;
  logic [KEY_W-1:0]  key_out;
  logic              key_ok;
  logic              key_err;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic [DATA_W-1:0] core_data;
  logic [CHK_W-1:0]  core_chk;
  logic              core_en;
  logic [DATA_W-1:0] core_dout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Core stub: flips bit 0 of the data word
  assign core_dout = core_data ^ 32'h1;

  c499_key_seq_ctrl #(
    .KEY_W  (KEY_W),
    .DATA_W (DATA_W),
    .CHK_W  (CHK_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_sdi    (key_sdi),
    .key_sen    (key_sen),
    .key_commit (key_commit),
    .key_out    (key_out),
    .key_ok     (key_ok),
    .key_err    (key_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chk     (in_chk),
    .core_data  (core_data),
    .core_chk   (core_chk),
    .core_en    (core_en),
    .core_dout  (core_dout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  // Expected key_out given the committed key and whether a word is settling
  function automatic logic [KEY_W-1:0] expKey(input logic [KEY_W-1:0] k, input bit in_settle);
    return (SCRUB && !in_settle) ? '0 : k;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then step past the next rising edge
  task automatic applyStimulus(input logic sen, input logic sdi, input logic commit,
                               input logic valid, input logic [DATA_W-1:0] data,
                               input logic [CHK_W-1:0] chk, input logic ordy);
    key_sen    = sen;
    key_sdi    = sdi;
    key_commit = commit;
    in_valid   = valid;
    in_data    = data;
    in_chk     = chk;
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  // Shift the low n bits of k, most significant first
  task automatic shiftKey(input logic [KEY_W-1:0] k, input int n, input logic ordy);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, k[i], 1'b0, 1'b0, '0, '0, ordy);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " key_out"},   64'(key_out),   64'h0);
    checkOutput({tag, " key_ok"},    64'(key_ok),    64'h0);
    checkOutput({tag, " key_err"},   64'(key_err),   64'h0);
    checkOutput({tag, " in_ready"},  64'(in_ready),  64'h0);
    checkOutput({tag, " out_valid"}, 64'(out_valid), 64'h0);
    checkOutput({tag, " core_en"},   64'(core_en),   64'h0);
  endtask

  initial begin
    rst        = 1'b1;
    key_sdi    = 1'b0;
    key_sen    = 1'b0;
    key_commit = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_chk     = '0;
    out_ready  = 1'b0;

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkResetOutputs("por");
    rst = 1'b0;

    // Incomplete shadow: commit flags an error and leaves the key untouched
    shiftKey(26'h3FF, 10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("short key_err",  64'(key_err),  64'h1);
    checkOutput("short key_ok",   64'(key_ok),   64'h0);
    checkOutput("short in_ready", 64'(in_ready), 64'h0);
    checkOutput("short key_out",  64'(key_out),  64'h0);

    // Full key after extra shifts: count saturates and the last 26 bits are kept
    shiftKey(KEY_A, KEY_W, 1'b0);
    checkOutput("pre-commit key_ok", 64'(key_ok), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("commit key_ok",   64'(key_ok),   64'h1);
    checkOutput("commit key_err",  64'(key_err),  64'h1);
    checkOutput("commit key_out",  64'(key_out),  64'(expKey(KEY_A, 1'b0)));
    checkOutput("commit in_ready", 64'(in_ready), 64'h1);

    // First codeword
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 8'hA5, 1'b0);
    checkOutput("acc core_en",   64'(core_en),   64'h1);
    checkOutput("acc core_data", 64'(core_data), 64'hDEADBEEF);
    checkOutput("acc core_chk",  64'(core_chk),  64'hA5);
    checkOutput("acc in_ready",  64'(in_ready),  64'h0);
    checkOutput("acc out_valid", 64'(out_valid), 64'h0);
    checkOutput("acc key_out",   64'(key_out),   64'(expKey(KEY_A, 1'b1)));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("settle1 core_en",   64'(core_en),   64'h1);
    checkOutput("settle1 out_valid", 64'(out_valid), 64'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("cap out_valid", 64'(out_valid), 64'h1);
    checkOutput("cap out_data",  64'(out_data),  64'hDEADBEEE);
    checkOutput("cap core_en",   64'(core_en),   64'h0);
    checkOutput("cap key_out",   64'(key_out),   64'(expKey(KEY_A, 1'b0)));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput("hold out_valid", 64'(out_valid), 64'h1);
      checkOutput("hold out_data",  64'(out_data),  64'hDEADBEEE);
      checkOutput("hold in_ready",  64'(in_ready),  64'h0);
    end
    checkOutput("idle core_data", 64'(core_data), 64'hDEADBEEF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("drain out_valid", 64'(out_valid), 64'h0);
    checkOutput("drain in_ready",  64'(in_ready),  64'h1);

    // Commit during SETTLE is deferred until the return to READY
    shiftKey(KEY_B, KEY_W, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 8'h3C, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("pend key_out",  64'(key_out),  64'(expKey(KEY_A, 1'b1)));
    checkOutput("pend in_ready", 64'(in_ready), 64'h0);
    checkOutput("pend key_ok",   64'(key_ok),   64'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("pend out_valid", 64'(out_valid), 64'h1);
    checkOutput("pend out_data",  64'(out_data),  64'h12345679);
    checkOutput("pend hold key",  64'(key_out),   64'(expKey(KEY_A, 1'b0)));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("pend hold2 key", 64'(key_out),   64'(expKey(KEY_A, 1'b0)));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("apply key_out",   64'(key_out),   64'(expKey(KEY_B, 1'b0)));
    checkOutput("apply in_ready",  64'(in_ready),  64'h1);
    checkOutput("apply out_valid", 64'(out_valid), 64'h0);

    // Next word runs with the new key
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0F0F0F0F, 8'h5A, 1'b0);
    checkOutput("w3 key_out", 64'(key_out), 64'(expKey(KEY_B, 1'b1)));
    checkOutput("w3 core_en", 64'(core_en), 64'h1);

    // Asynchronous reset mid-word clears everything without a clock edge
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkResetOutputs("async");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    checkResetOutputs("post");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
